strobe_rate_meter: RTL and testbench

- Measures an incoming strobe or clock-like signal in the 32.768 MHz domain: rising-edge count over a programmable gate, plus min/max edge-to-edge interval.
- Consumes the enable rates generated in the clocking tree and recovered symbol/bit clocks from the PSK receiver.
- Used for self-test of the enable tree and for checking the symbol-clock rate and jitter.
- A start/valid/ack handshake lets a control FSM or register bank read results.

---
 rtl/strobe_rate_meter.sv | 171 +++++++++++++++++
 tb/tb_strobe_rate_meter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strobe_rate_meter.sv
// Strobe rate meter: counts strobe events over a programmable gate aligned to the
// first event, and tracks the shortest and longest edge-to-edge interval.
module strobe_rate_meter #(
    parameter int GATE_W  = 26,
    parameter int CNT_W   = 26,
    parameter int PER_W   = 20,
    parameter int SYNC_EN = 1
) (
    input  logic              clk32M768,
    input  logic              rst,
    input  logic              strobe_in,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic              start,
    input  logic              result_ack,
    output logic              busy,
    output logic              result_valid,
    output logic [CNT_W-1:0]  edge_count,
    output logic [PER_W-1:0]  period_min,
    output logic [PER_W-1:0]  period_max,
    output logic              timeout,
    output logic              overflow
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_GATE = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [GATE_W-1:0] G_ONE = GATE_W'(1);

    logic              ev;

    logic [1:0]        state_q,     state_d;
    logic [GATE_W-1:0] gate_len_q,  gate_len_d;
    logic [GATE_W-1:0] wait_q,      wait_d;
    logic [GATE_W-1:0] gate_left_q, gate_left_d;
    logic [PER_W-1:0]  ival_q,      ival_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [PER_W-1:0]  pmin_q,      pmin_d;
    logic [PER_W-1:0]  pmax_q,      pmax_d;
    logic              tmo_q,       tmo_d;
    logic              ovf_q,       ovf_d;

    logic              start_ok;
    logic [PER_W-1:0]  ival_next;

    generate
        if (SYNC_EN != 0) begin : g_sync
            // sync_q[0..2] = s1, s2, s3; ev fires once per rising edge of s2
            logic [2:0] sync_q;
            always_ff @(posedge clk32M768) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[1:0], strobe_in};
                end
            end
            assign ev = sync_q[1] & ~sync_q[2];
        end else begin : g_nosync
            assign ev = strobe_in;
        end
    endgenerate

    assign start_ok  = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign ival_next = (ival_q == '1) ? ival_q : ival_q + PER_W'(1);

    always_comb begin
        state_d     = state_q;
        gate_len_d  = gate_len_q;
        wait_d      = wait_q;
        gate_left_d = gate_left_q;
        ival_d      = ival_q;
        cnt_d       = cnt_q;
        pmin_d      = pmin_q;
        pmax_d      = pmax_q;
        tmo_d       = tmo_q;
        ovf_d       = ovf_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d    = S_ARM;
                    gate_len_d = (gate_cycles == '0) ? G_ONE : gate_cycles;
                    wait_d     = '0;
                    ival_d     = '0;
                    cnt_d      = '0;
                    pmin_d     = '1;
                    pmax_d     = '0;
                    tmo_d      = 1'b0;
                    ovf_d      = 1'b0;
                end else if ((state_q == S_DONE) && result_ack) begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (ev) begin
                    state_d     = S_GATE;
                    ival_d      = '0;
                    gate_left_d = gate_len_q;
                end else if (wait_q == gate_len_q - G_ONE) begin
                    state_d = S_DONE;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + G_ONE;
                end
            end
            S_GATE: begin
                if (ival_q == '1) begin
                    ovf_d = 1'b1;
                end
                // An event measures the interval ending on this cycle, then restarts it
                if (ev) begin
                    if (cnt_q == '1) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (ival_next <= pmin_q) begin
                        pmin_d = ival_next;
                    end
                    if (ival_next >= pmax_q) begin
                        pmax_d = ival_next;
                    end
                    ival_d = '0;
                end else begin
                    ival_d = ival_next;
                end
                gate_left_d = gate_left_q - G_ONE;
                if (gate_left_q == G_ONE) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk32M768) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gate_len_q  <= '0;
            wait_q      <= '0;
            gate_left_q <= '0;
            ival_q      <= '0;
            cnt_q       <= '0;
            pmin_q      <= '1;
            pmax_q      <= '0;
            tmo_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_len_q  <= gate_len_d;
            wait_q      <= wait_d;
            gate_left_q <= gate_left_d;
            ival_q      <= ival_d;
            cnt_q       <= cnt_d;
            pmin_q      <= pmin_d;
            pmax_q      <= pmax_d;
            tmo_q       <= tmo_d;
            ovf_q       <= ovf_d;
        end
    end

    assign busy         = (state_q == S_ARM) | (state_q == S_GATE);
    assign result_valid = (state_q == S_DONE);
    assign edge_count   = cnt_q;
    assign period_min   = pmin_q;
    assign period_max   = pmax_q;
    assign timeout      = tmo_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_strobe_rate_meter.sv
// Bench for strobe_rate_meter: three instances (unsynchronised, synchronised, narrow
// counters) checked against an event-list reference model of the measurement.
module tb_strobe_rate_meter;

    localparam int MAXL = 34000;

    logic        clk = 1'b0;
    logic        rst;
    logic        strobe_in;
    logic        result_ack;
    logic [25:0] gate_cycles;
    logic        start0, start1, start2;

    logic        busy0, rv0, tmo0, ovf0;
    logic [25:0] cnt0;
    logic [19:0] pmin0, pmax0;
    logic        busy1, rv1, tmo1, ovf1;
    logic [25:0] cnt1;
    logic [19:0] pmin1, pmax1;
    logic        busy2, rv2, tmo2, ovf2;
    logic [3:0]  cnt2;
    logic [3:0]  pmin2, pmax2;

    int          checks   = 0;
    int          failures = 0;
    int          sel      = 0;
    bit          pat [MAXL];

    logic        o_busy, o_rv, o_tmo, o_ovf;
    logic [31:0] o_cnt, o_min, o_max;

    always #5 clk = ~clk;

    strobe_rate_meter #(.GATE_W(26), .CNT_W(26), .PER_W(20), .SYNC_EN(0)) u_dut0 (
        .clk32M768(clk), .rst(rst), .strobe_in(strobe_in), .gate_cycles(gate_cycles),
        .start(start0), .result_ack(result_ack), .busy(busy0), .result_valid(rv0),
        .edge_count(cnt0), .period_min(pmin0), .period_max(pmax0),
        .timeout(tmo0), .overflow(ovf0));

    strobe_rate_meter #(.GATE_W(26), .CNT_W(26), .PER_W(20), .SYNC_EN(1)) u_dut1 (
        .clk32M768(clk), .rst(rst), .strobe_in(strobe_in), .gate_cycles(gate_cycles),
        .start(start1), .result_ack(result_ack), .busy(busy1), .result_valid(rv1),
        .edge_count(cnt1), .period_min(pmin1), .period_max(pmax1),
        .timeout(tmo1), .overflow(ovf1));

    strobe_rate_meter #(.GATE_W(26), .CNT_W(4), .PER_W(4), .SYNC_EN(0)) u_dut2 (
        .clk32M768(clk), .rst(rst), .strobe_in(strobe_in), .gate_cycles(gate_cycles),
        .start(start2), .result_ack(result_ack), .busy(busy2), .result_valid(rv2),
        .edge_count(cnt2), .period_min(pmin2), .period_max(pmax2),
        .timeout(tmo2), .overflow(ovf2));

    always_comb begin
        o_busy = busy0; o_rv = rv0; o_tmo = tmo0; o_ovf = ovf0;
        o_cnt = 32'(cnt0); o_min = 32'(pmin0); o_max = 32'(pmax0);
        case (sel)
            1: begin
                o_busy = busy1; o_rv = rv1; o_tmo = tmo1; o_ovf = ovf1;
                o_cnt = 32'(cnt1); o_min = 32'(pmin1); o_max = 32'(pmax1);
            end
            2: begin
                o_busy = busy2; o_rv = rv2; o_tmo = tmo2; o_ovf = ovf2;
                o_cnt = 32'(cnt2); o_min = 32'(pmin2); o_max = 32'(pmax2);
            end
            default: ;
        endcase
    end

    task automatic set_start(input int s, input bit v);
        start0 = v && (s == 0);
        start1 = v && (s == 1);
        start2 = v && (s == 2);
    endtask

    task automatic clear_pat();
        for (int i = 0; i < MAXL; i++) pat[i] = 1'b0;
    endtask

    // Event seen by the measurement logic in cycle i (i = 0 is the start cycle)
    function automatic bit ev_at(input int i, input bit sync);
        if (sync)
            return (i >= 2 && pat[i-2]) && !(i >= 3 && pat[i-3]);
        return pat[i];
    endfunction

    task automatic model(input int s, input int g, output int e_done, output int e_cnt,
                         output int e_min, output int e_max, output bit e_tmo, output bit e_ovf);
        int geff, arm, last, n, gap, cmax, pmaxv;
        bit sync;
        sync  = (s == 1);
        cmax  = (s == 2) ? 15 : (1 << 26) - 1;
        pmaxv = (s == 2) ? 15 : (1 << 20) - 1;
        geff  = (g == 0) ? 1 : g;
        arm   = -1;
        for (int i = 1; i <= geff; i++) begin
            if (arm < 0 && ev_at(i, sync)) arm = i;
        end
        e_min = pmaxv; e_max = 0; e_ovf = 1'b0; e_tmo = 1'b0; e_cnt = 0;
        if (arm < 0) begin
            e_done = geff;
            e_tmo  = 1'b1;
        end else begin
            last = arm; n = 0;
            for (int i = arm + 1; i <= arm + geff; i++) begin
                if (ev_at(i, sync)) begin
                    n++;
                    gap = i - last;
                    if (gap > pmaxv) begin gap = pmaxv; e_ovf = 1'b1; end
                    if (gap < e_min) e_min = gap;
                    if (gap > e_max) e_max = gap;
                    last = i;
                end
            end
            if (arm + geff - last > pmaxv) e_ovf = 1'b1;
            if (n > cmax) begin n = cmax; e_ovf = 1'b1; end
            e_cnt  = n;
            e_done = arm + geff;
        end
    endtask

    task automatic measure(input int s, input int g, input int poke, input bit with_ack,
                           input string name);
        int e_done, e_cnt, e_min, e_max, i;
        bit e_tmo, e_ovf, found;
        model(s, g, e_done, e_cnt, e_min, e_max, e_tmo, e_ovf);
        sel = s;
        @(negedge clk);
        set_start(s, 1'b1);
        gate_cycles = 26'(g);
        strobe_in   = pat[0];
        result_ack  = with_ack;
        @(posedge clk);
        found = 1'b0; i = 0;
        while (!found && i < e_done + 8 && i < MAXL - 2) begin
            @(negedge clk);
            i++;
            set_start(s, i == poke);
            result_ack  = 1'b0;
            strobe_in   = pat[i];
            gate_cycles = 26'($urandom);
            @(posedge clk);
            #1;
            if (i == 1 && e_done > 1) begin
                checks++;
                if (o_busy !== 1'b1 || o_rv !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_latency: busy=%b rv=%b required busy=1 rv=0", name, o_busy, o_rv);
                end
            end
            if (o_rv === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || i != e_done) begin
            failures++;
            $display("FAIL %s done_time: got cycle %0d (found=%0b) required %0d", name, i, found, e_done);
        end
        if (found) begin
            checks++;
            if (o_cnt !== 32'(e_cnt)) begin
                failures++;
                $display("FAIL %s edge_count: got %0d required %0d", name, o_cnt, e_cnt);
            end
            checks++;
            if (o_min !== 32'(e_min) || o_max !== 32'(e_max)) begin
                failures++;
                $display("FAIL %s period: got min=%0d max=%0d required min=%0d max=%0d", name, o_min, o_max, e_min, e_max);
            end
            checks++;
            if (o_tmo !== e_tmo || o_ovf !== e_ovf || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL %s flags: got tmo=%b ovf=%b busy=%b required tmo=%b ovf=%b busy=0", name, o_tmo, o_ovf, o_busy, e_tmo, e_ovf);
            end
        end
        @(negedge clk);
        set_start(s, 1'b0);
        strobe_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; strobe_in = 1'b0; result_ack = 1'b0; gate_cycles = '0;
        set_start(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || rv0 !== 1'b0 || cnt0 !== '0 || pmin0 !== 20'hFFFFF || pmax0 !== '0 || tmo0 !== 1'b0 || ovf0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut0: busy=%b rv=%b cnt=%0d min=%h max=%0d tmo=%b ovf=%b required 0 0 0 fffff 0 0 0", busy0, rv0, cnt0, pmin0, pmax0, tmo0, ovf0);
        end
        checks++;
        if (busy2 !== 1'b0 || rv2 !== 1'b0 || pmin2 !== 4'hF || pmax2 !== '0 || cnt2 !== '0) begin
            failures++;
            $display("FAIL reset_dut2: busy=%b rv=%b cnt=%0d min=%h max=%0d required 0 0 0 f 0", busy2, rv2, cnt2, pmin2, pmax2);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_periodic();
        clear_pat();
        for (int i = 5; i < MAXL; i += 32) pat[i] = 1'b1;
        measure(0, 32768, -1, 1'b0, "periodic_32");
    endtask

    task automatic test_square_sync();
        clear_pat();
        for (int i = 0; i < MAXL; i++) pat[i] = ((i % 64) >= 32);
        measure(1, 6400, -1, 1'b0, "square_sync");
    endtask

    task automatic test_jitter();
        int p;
        clear_pat();
        p = 3;
        for (int k = 0; p < 4000; k++) begin
            pat[p] = 1'b1;
            p += (k % 2 == 0) ? 30 : 34;
        end
        measure(0, 3200, -1, 1'b0, "jitter_30_34");
    endtask

    task automatic test_timeout();
        clear_pat();
        measure(0, 1000, -1, 1'b0, "timeout_1000");
        measure(0, 0, -1, 1'b0, "gate_zero");
    endtask

    task automatic test_handshake();
        clear_pat();
        for (int i = 5; i < 2000; i += 32) pat[i] = 1'b1;
        measure(0, 640, 100, 1'b0, "start_in_gate");
        measure(0, 640, -1, 1'b1, "start_ack_done");
        @(negedge clk);
        result_ack = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rv0 !== 1'b0 || busy0 !== 1'b0 || cnt0 !== 26'd20 || pmin0 !== 20'd32) begin
            failures++;
            $display("FAIL ack_idle: rv=%b busy=%b cnt=%0d min=%0d required rv=0 busy=0 cnt=20 min=32", rv0, busy0, cnt0, pmin0);
        end
        @(negedge clk);
        result_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        clear_pat();
        for (int i = 5; i < 2000; i += 32) pat[i] = 1'b1;
        @(negedge clk);
        set_start(0, 1'b1); gate_cycles = 26'd1000; strobe_in = pat[0];
        for (int i = 1; i < 200; i++) begin
            @(negedge clk);
            set_start(0, 1'b0); strobe_in = pat[i];
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0 || rv0 !== 1'b0 || cnt0 !== '0 || pmin0 !== 20'hFFFFF || pmax0 !== '0 || tmo0 !== 1'b0 || ovf0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_gate: busy=%b rv=%b cnt=%0d min=%h max=%0d tmo=%b ovf=%b required 0 0 0 fffff 0 0 0", busy0, rv0, cnt0, pmin0, pmax0, tmo0, ovf0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 200; i < 260; i++) begin
            @(negedge clk);
            strobe_in = pat[i];
        end
        #1;
        checks++;
        if (busy0 !== 1'b0 || rv0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_stays_idle: busy=%b rv=%b required busy=0 rv=0", busy0, rv0);
        end
        strobe_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_saturation();
        clear_pat();
        pat[3] = 1'b1;
        measure(2, 100, -1, 1'b0, "sat_period");
        clear_pat();
        for (int k = 0; k <= 20; k++) pat[3 + 3*k] = 1'b1;
        measure(2, 100, -1, 1'b0, "sat_count");
    endtask

    task automatic test_random();
        int s, g, dens;
        for (int it = 0; it < 10; it++) begin
            s    = $urandom_range(0, 2);
            g    = $urandom_range(0, 300);
            dens = $urandom_range(0, 40);
            clear_pat();
            for (int i = 0; i < 700; i++) pat[i] = ($urandom_range(0, 99) < dens);
            measure(s, g, -1, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_square_sync();
        test_jitter();
        test_timeout();
        test_handshake();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
